// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single synchronous memory port.
// Round-robin or fixed priority with starvation guard and bus lock.
module mem_port_arbiter #(
  parameter int RR_MODE      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        p0_req_i,
  input  logic        p0_lock_i,
  input  logic [3:0]  p0_wstrb_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_i,
  input  logic        p1_lock_i,
  input  logic [3:0]  p1_wstrb_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        mem_enable_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wvalue_o,
  input  logic [31:0] mem_rvalue_i
);

  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic       r_rr_last;
  logic       r_lock_vld;
  logic       r_lock_own;
  logic       r_rd_pend;
  logic       r_rd_own;
  logic [7:0] r_starve;

  logic [1:0] w_req;
  logic [1:0] w_lock;
  logic [1:0] w_gnt;
  logic       w_hold;
  logic       w_p1_first;
  logic       w_any;
  logic       w_win;
  logic       w_rd;
  logic [3:0] w_win_wstrb;

  assign w_req  = {p1_req_i, p0_req_i};
  assign w_lock = {p1_lock_i, p0_lock_i};
  assign w_hold = r_lock_vld & w_lock[r_lock_own];

  assign w_p1_first = (RR_MODE != 0) ? ~r_rr_last
                                     : (r_starve >= LIM);

  // Grant is gated by reset so every output reads 0 while held in reset.
  always_comb begin
    w_gnt = 2'b00;
    if (!rstn_i) begin
      w_gnt = 2'b00;
    end else if (w_hold) begin
      w_gnt[r_lock_own] = w_req[r_lock_own];
    end else begin
      unique case (1'b1)
        (w_req == 2'b01): w_gnt = 2'b01;
        (w_req == 2'b10): w_gnt = 2'b10;
        (w_req == 2'b11): w_gnt = w_p1_first ? 2'b10 : 2'b01;
        default:          w_gnt = 2'b00;
      endcase
    end
  end

  assign w_any       = |w_gnt;
  assign w_win       = w_gnt[1];
  assign w_win_wstrb = w_win ? p1_wstrb_i : p0_wstrb_i;
  assign w_rd        = w_any & (w_win_wstrb == 4'd0);

  assign p0_gnt_o     = w_gnt[0];
  assign p1_gnt_o     = w_gnt[1];
  assign mem_enable_o = w_any;
  assign mem_wstrb_o  = w_any ? w_win_wstrb : 4'd0;
  assign mem_addr_o   = w_gnt[1] ? p1_addr_i
                      : w_gnt[0] ? p0_addr_i : 32'd0;
  assign mem_wvalue_o = w_gnt[1] ? p1_wdata_i
                      : w_gnt[0] ? p0_wdata_i : 32'd0;

  assign p0_rvalid_o = r_rd_pend & ~r_rd_own;
  assign p1_rvalid_o = r_rd_pend & r_rd_own;
  assign p0_rdata_o  = p0_rvalid_o ? mem_rvalue_i : 32'd0;
  assign p1_rdata_o  = p1_rvalid_o ? mem_rvalue_i : 32'd0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rr_last  <= 1'b1;
      r_lock_vld <= 1'b0;
      r_lock_own <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_own   <= 1'b0;
      r_starve   <= 8'd0;
    end else begin
      if (w_any) r_rr_last <= w_win;
      if (w_any && w_lock[w_win]) begin
        r_lock_vld <= 1'b1;
        r_lock_own <= w_win;
      end else if (r_lock_vld && !w_hold) begin
        r_lock_vld <= 1'b0;
      end
      if (p1_req_i && !w_gnt[1]) begin
        if (r_starve != 8'hFF) r_starve <= r_starve + 8'd1;
      end else begin
        r_starve <= 8'd0;
      end
      r_rd_pend <= w_rd;
      if (w_rd) r_rd_own <= w_win;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, corner sequences,
// and random traffic against a rule-level model (RR and fixed-priority).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        p0_req, p0_lock, p1_req, p1_lock;
  logic [3:0]  p0_ws, p1_ws;
  logic [31:0] p0_a, p0_d, p1_a, p1_d, rv;

  typedef struct packed {
    logic        g0, g1, v0, v1;
    logic [31:0] rd0, rd1;
    logic        en;
    logic [3:0]  ws;
    logic [31:0] ad, wd;
  } out_t;

  logic        a_g0, a_g1, a_v0, a_v1, a_en;
  logic [31:0] a_rd0, a_rd1, a_ad, a_wd;
  logic [3:0]  a_ws;
  logic        b_g0, b_g1, b_v0, b_v1, b_en;
  logic [31:0] b_rd0, b_rd1, b_ad, b_wd;
  logic [3:0]  b_ws;

  mem_port_arbiter #(.RR_MODE(1), .STARVE_LIMIT(8)) u_rr (
    .clk_i(clk), .rstn_i(rstn),
    .p0_req_i(p0_req), .p0_lock_i(p0_lock), .p0_wstrb_i(p0_ws),
    .p0_addr_i(p0_a), .p0_wdata_i(p0_d),
    .p0_gnt_o(a_g0), .p0_rvalid_o(a_v0), .p0_rdata_o(a_rd0),
    .p1_req_i(p1_req), .p1_lock_i(p1_lock), .p1_wstrb_i(p1_ws),
    .p1_addr_i(p1_a), .p1_wdata_i(p1_d),
    .p1_gnt_o(a_g1), .p1_rvalid_o(a_v1), .p1_rdata_o(a_rd1),
    .mem_enable_o(a_en), .mem_wstrb_o(a_ws), .mem_addr_o(a_ad),
    .mem_wvalue_o(a_wd), .mem_rvalue_i(rv)
  );

  mem_port_arbiter #(.RR_MODE(0), .STARVE_LIMIT(3)) u_fp (
    .clk_i(clk), .rstn_i(rstn),
    .p0_req_i(p0_req), .p0_lock_i(p0_lock), .p0_wstrb_i(p0_ws),
    .p0_addr_i(p0_a), .p0_wdata_i(p0_d),
    .p0_gnt_o(b_g0), .p0_rvalid_o(b_v0), .p0_rdata_o(b_rd0),
    .p1_req_i(p1_req), .p1_lock_i(p1_lock), .p1_wstrb_i(p1_ws),
    .p1_addr_i(p1_a), .p1_wdata_i(p1_d),
    .p1_gnt_o(b_g1), .p1_rvalid_o(b_v1), .p1_rdata_o(b_rd1),
    .mem_enable_o(b_en), .mem_wstrb_o(b_ws), .mem_addr_o(b_ad),
    .mem_wvalue_o(b_wd), .mem_rvalue_i(rv)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic out_t dut_out(int k);
    out_t o;
    if (k == 0) o = '{a_g0, a_g1, a_v0, a_v1, a_rd0, a_rd1,
                      a_en, a_ws, a_ad, a_wd};
    else        o = '{b_g0, b_g1, b_v0, b_v1, b_rd0, b_rd1,
                      b_en, b_ws, b_ad, b_wd};
    return o;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_out(input string t, input out_t a, input out_t e);
    cmp({t, ".gnt0"},   32'(a.g0),  32'(e.g0));
    cmp({t, ".gnt1"},   32'(a.g1),  32'(e.g1));
    cmp({t, ".rvalid0"}, 32'(a.v0), 32'(e.v0));
    cmp({t, ".rvalid1"}, 32'(a.v1), 32'(e.v1));
    cmp({t, ".rdata0"}, a.rd0, e.rd0);
    cmp({t, ".rdata1"}, a.rd1, e.rd1);
    cmp({t, ".mem_en"}, 32'(a.en),  32'(e.en));
    cmp({t, ".mem_ws"}, 32'(a.ws),  32'(e.ws));
    cmp({t, ".mem_ad"}, a.ad, e.ad);
    cmp({t, ".mem_wd"}, a.wd, e.wd);
  endtask

  // Reference model: one state set per instance, rules applied directly.
  int RRM[2]  = '{1, 0};
  int LIMV[2] = '{8, 3};
  int m_last[2], m_lkv[2], m_lko[2], m_pend[2], m_pown[2], m_st[2];

  function automatic logic rq(int p);
    return p != 0 ? p1_req : p0_req;
  endfunction
  function automatic logic lk(int p);
    return p != 0 ? p1_lock : p0_lock;
  endfunction
  function automatic logic [3:0] wsx(int p);
    return p != 0 ? p1_ws : p0_ws;
  endfunction

  function automatic int win(int k);
    if (m_lkv[k] != 0 && lk(m_lko[k]))
      return rq(m_lko[k]) ? m_lko[k] : -1;
    if (!p0_req && !p1_req) return -1;
    if (p0_req != p1_req) return p1_req ? 1 : 0;
    if (RRM[k] != 0) return 1 - m_last[k];
    return (m_st[k] >= LIMV[k]) ? 1 : 0;
  endfunction

  function automatic out_t mexp(int k);
    out_t e = '0;
    int w = win(k);
    e.g0 = (w == 0);
    e.g1 = (w == 1);
    if (w >= 0) begin
      e.en = 1'b1;
      e.ws = wsx(w);
      e.ad = (w == 1) ? p1_a : p0_a;
      e.wd = (w == 1) ? p1_d : p0_d;
    end
    if (m_pend[k] != 0) begin
      if (m_pown[k] == 0) begin e.v0 = 1'b1; e.rd0 = rv; end
      else begin e.v1 = 1'b1; e.rd1 = rv; end
    end
    return e;
  endfunction

  task automatic mupd(input int k);
    int w = win(k);
    if (w >= 0) m_last[k] = w;
    if (w >= 0 && lk(w)) begin
      m_lkv[k] = 1;
      m_lko[k] = w;
    end else if (m_lkv[k] != 0 && !lk(m_lko[k])) begin
      m_lkv[k] = 0;
    end
    if (p1_req && w != 1) m_st[k] = (m_st[k] < 255) ? m_st[k] + 1 : 255;
    else m_st[k] = 0;
    m_pend[k] = (w >= 0 && wsx(w) == 4'd0) ? 1 : 0;
    if (m_pend[k] != 0) m_pown[k] = w;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1; m_lkv[k] = 0; m_lko[k] = 0;
      m_pend[k] = 0; m_pown[k] = 0; m_st[k] = 0;
    end
  endtask

  task automatic idle_in();
    p0_req = 0; p0_lock = 0; p0_ws = 0; p0_a = 0; p0_d = 0;
    p1_req = 0; p1_lock = 0; p1_ws = 0; p1_a = 0; p1_d = 0;
    rv = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    m_reset();
  endtask

  typedef struct {
    logic        r0, r1, l0, l1;
    logic [3:0]  s0, s1;
    logic [31:0] a0, a1, d0, d1, rv;
    out_t        e;
  } vec_t;

  function automatic vec_t mkv(
    logic r0, logic r1, logic l0, logic l1,
    logic [3:0] s0, logic [3:0] s1,
    logic [31:0] a0, logic [31:0] a1,
    logic [31:0] d0, logic [31:0] d1, logic [31:0] rvv,
    logic g0, logic g1, logic v0, logic v1,
    logic [31:0] rd0, logic [31:0] rd1, logic en,
    logic [3:0] ws, logic [31:0] ad, logic [31:0] wd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
    v.s0 = s0; v.s1 = s1; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.rv = rvv;
    v.e = '{g0, g1, v0, v1, rd0, rd1, en, ws, ad, wd};
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    tbl[0] = mkv(1,0,0,0, 0,0, 32'h100,0, 0,0, 0,
                 1,0,0,0, 0,0, 1,0, 32'h100,0);
    tbl[1] = mkv(0,0,0,0, 0,0, 0,0, 0,0, 32'hDEADBEEF,
                 0,0,1,0, 32'hDEADBEEF,0, 0,0, 0,0);
    tbl[2] = mkv(1,1,0,0, 0,0, 32'h10,32'h20, 32'h11,32'h22, 0,
                 0,1,0,0, 0,0, 1,0, 32'h20,32'h22);
    tbl[3] = mkv(1,1,0,0, 0,0, 32'h10,32'h20, 32'h11,32'h22,
                 32'hAAAA0001,
                 1,0,0,1, 0,32'hAAAA0001, 1,0, 32'h10,32'h11);
    tbl[4] = mkv(1,1,0,0, 0,0, 32'h10,32'h20, 32'h11,32'h22,
                 32'hBBBB0002,
                 0,1,1,0, 32'hBBBB0002,0, 1,0, 32'h20,32'h22);
    tbl[5] = mkv(0,1,0,1, 0,4'b0011, 0,32'h40, 0,32'h1234,
                 32'hCCCC0003,
                 0,1,0,1, 0,32'hCCCC0003, 1,4'b0011, 32'h40,32'h1234);
    tbl[6] = mkv(1,1,0,1, 0,4'b0011, 32'h10,32'h40, 32'h11,32'h1234,
                 32'h77,
                 0,1,0,0, 0,0, 1,4'b0011, 32'h40,32'h1234);
    tbl[7] = mkv(1,0,0,1, 0,0, 32'h10,0, 32'h11,0, 32'h88,
                 0,0,0,0, 0,0, 0,0, 0,0);
    tbl[8] = mkv(1,0,0,0, 0,0, 32'h10,0, 32'h11,0, 0,
                 1,0,0,0, 0,0, 1,0, 32'h10,32'h11);
    tbl[9] = mkv(0,0,0,0, 0,0, 0,0, 0,0, 32'hCAFEF00D,
                 0,0,1,0, 32'hCAFEF00D,0, 0,0, 0,0);

    // Reset state, with requests present to prove gating.
    idle_in();
    rstn = 1'b0;
    p0_req = 1; p1_req = 1; p0_a = 32'h5; p1_a = 32'h6;
    @(negedge clk);
    cmp_out("rst_rr", dut_out(0), '0);
    cmp_out("rst_fp", dut_out(1), '0);
    @(posedge clk); #1;
    do_reset();

    foreach (tbl[i]) begin
      p0_req = tbl[i].r0; p1_req = tbl[i].r1;
      p0_lock = tbl[i].l0; p1_lock = tbl[i].l1;
      p0_ws = tbl[i].s0; p1_ws = tbl[i].s1;
      p0_a = tbl[i].a0; p1_a = tbl[i].a1;
      p0_d = tbl[i].d0; p1_d = tbl[i].d1;
      rv = tbl[i].rv;
      @(negedge clk);
      cmp_out($sformatf("vec%0d", i), dut_out(0), tbl[i].e);
      @(posedge clk); #1;
    end

    // Continuous contention: RR alternates, fixed priority 0,0,0,1.
    do_reset();
    p0_req = 1; p1_req = 1; p0_a = 32'h111; p1_a = 32'h222;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cmp($sformatf("rr_gnt0_%0d", i), 32'(a_g0), 32'(i % 2 == 0));
      cmp($sformatf("rr_addr_%0d", i), a_ad,
          (i % 2 == 0) ? 32'h111 : 32'h222);
      cmp($sformatf("fp_gnt1_%0d", i), 32'(b_g1), 32'(i % 4 == 3));
      cmp($sformatf("fp_addr_%0d", i), b_ad,
          (i % 4 == 3) ? 32'h222 : 32'h111);
      @(posedge clk); #1;
    end

    // Reset asserted while a read is pending.
    do_reset();
    p0_req = 1; p0_a = 32'h300;
    @(negedge clk);
    cmp("mid_gnt", 32'(a_g0), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    rv = 32'h55;
    #1;
    cmp_out("mid_rst_rr", dut_out(0), '0);
    cmp_out("mid_rst_fp", dut_out(1), '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    p0_req = 0;
    @(negedge clk);
    cmp("post_rst_rv_rr", 32'({a_v0, a_v1}), 32'd0);
    cmp("post_rst_rv_fp", 32'({b_v0, b_v1}), 32'd0);
    @(posedge clk); #1;

    // Random traffic against the model, both modes.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      out_t e0, e1;
      p0_req  = ($urandom_range(1, 0) == 1);
      p1_req  = ($urandom_range(1, 0) == 1);
      p0_lock = ($urandom_range(3, 0) == 0);
      p1_lock = ($urandom_range(3, 0) == 0);
      p0_ws = ($urandom_range(1, 0) == 1) ? 4'd0 : 4'($urandom);
      p1_ws = ($urandom_range(1, 0) == 1) ? 4'd0 : 4'($urandom);
      p0_a = $urandom; p1_a = $urandom;
      p0_d = $urandom; p1_d = $urandom;
      rv = $urandom;
      @(negedge clk);
      e0 = mexp(0);
      e1 = mexp(1);
      cmp_out($sformatf("rnd_rr%0d", i), dut_out(0), e0);
      cmp_out($sformatf("rnd_fp%0d", i), dut_out(1), e1);
      mupd(0);
      mupd(1);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
